rc4_keystream_gen: RTL
======================

// Module: rc4_keystream_gen
// PURPOSE
//   RC4 keystream source feeding the RC4 XOR/write stage (outputToXor/xor_sig/couterPixel inputs).
//   Runs RC4 key scheduling (KSA) on a latched key, then emits one PRGA keystream byte per request.
//   Holds a 256x8 S-box in a register array; i/j indices are 8-bit and wrap mod 256.
// PARAMETERS
//   KEY_BYTES  8    key length in bytes (1..32); key byte n = key_i[8*(KEY_BYTES-n)-1 -: 8] (MSB first)
//   PIX_W      20   width of couterPixel_o
//   DROP_N     256  bytes discarded after KSA (used only with RC4_DROP_EN)
// PORTS
//   clk            in   1            system clock, rising edge
//   n_rst          in   1            asynchronous active-low reset
//   start_i        in   1            latch key_i, (re)start full KSA
//   key_i          in   8*KEY_BYTES  RC4 key
//   next_i         in   1            request one keystream byte
//   outputToXor_o  out  8            keystream byte, valid while xor_sig_o=1
//   xor_sig_o      out  1            1-cycle strobe: byte valid
//   couterPixel_o  out  PIX_W        index of the byte on outputToXor_o (0 = first after ready)
//   ready_o        out  1            KSA complete, next_i accepted
//   busy_o         out  1            INIT/KSA/DROP/PRGA in progress
// BEHAVIOUR
//   Reset (n_rst=0, async): state IDLE, i=j=0, all outputs 0, S-box contents don't-care.
//   States: IDLE -> INIT -> KSA -> [DROP] -> READY <-> GEN_SWAP -> GEN_OUT -> READY.
//   IDLE: wait start_i. start_i sampled in ANY state: latch key, cnt=0, j=0, ready_o=0 -> INIT.
//   INIT: S[cnt]=cnt, one entry/cycle, 256 cycles -> KSA (cnt=0, j=0).
//   KSA: j'=j+S[cnt]+key[cnt mod KEY_BYTES] (8-bit wrap); swap S[cnt],S[j']; 256 cycles -> READY.
//   ready_o registered high exactly 512 cycles after the start_i sampling edge (no drop); i=j=0.
//   READY: next_i=1 -> GEN_SWAP; next_i=0 -> hold. next_i ignored outside READY (no queueing).
//   GEN_SWAP: i'=i+1; j'=j+S[i']; swap S[i'],S[j'].
//   GEN_OUT: outputToXor_o=S[S[i]+S[j]] (8-bit sum), xor_sig_o=1 for this cycle only -> READY.
//   Latency: next_i sampled at edge N -> xor_sig_o high for the cycle after edge N+2.
//   Throughput: 1 byte per 3 cycles with next_i held high (READY, SWAP, OUT).
//   couterPixel_o: 0 at first output, +1 after each strobe, wraps 2^PIX_W-1 -> 0; reset to 0 on start_i.
//   outputToXor_o holds last byte between strobes; cleared only by reset/start_i.
//   start_i and next_i together: start_i wins, request dropped.
//   start_i during GEN_*: operation aborted, no strobe emitted.
//   busy_o = (state != IDLE && state != READY); ready_o = (state == READY).
//   key_i may change after start_i; only latched copy is used.
// CONFIGURATION
//   RC4_DROP_EN defined: after KSA enter DROP, run DROP_N PRGA steps (1 step/cycle, no strobes,
//     couterPixel_o unchanged); ready_o then rises 512+DROP_N cycles after start (RC4-drop[N]).
//   RC4_DROP_EN undefined: no DROP state; DROP_N ignored; KSA -> READY directly.
// TESTING
//   KEY_BYTES=3, key "Key", start, 10 next_i -> EB 9F 77 81 B7 34 CA 72 A7 19, couterPixel 0..9.
//   KEY_BYTES=4, key "Wiki" -> 60 44 DB 6D 41; ready_o exactly 512 cycles after start.
//   KEY_BYTES=6, key "Secret", next_i held high 8 cycles -> strobes every 3 cycles, 04 D4 6B 05 3C ...
//   start_i mid-KSA with "Wiki" after "Key" -> KSA restarts, first byte 60, couterPixel 0.
//   next_i before ready_o, and n_rst low during GEN_SWAP -> no strobe; outputs 0, state IDLE.
//   RC4_DROP_EN, DROP_N=256, key "Key" -> ready at 768 cycles, first byte = byte 256 of plain stream.

Source files
------------

// File: rtl/rc4_keystream_gen.sv
// RC4 keystream source: key scheduling on a latched key, then one PRGA byte per request.
// Define RC4_DROP_EN to discard DROP_N keystream bytes after key scheduling (RC4-drop[N]).
module rc4_keystream_gen #(
  parameter int unsigned KEY_BYTES = 8,
  parameter int unsigned PIX_W     = 20,
  parameter int unsigned DROP_N    = 256
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  input  logic                   next_i,
  output logic [7:0]             outputToXor_o,
  output logic                   xor_sig_o,
  output logic [PIX_W-1:0]       couterPixel_o,
  output logic                   ready_o,
  output logic                   busy_o
);

  localparam int unsigned KEY_W  = 8 * KEY_BYTES;
  localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE, INIT, KSA, DROP, READY, GEN_SWAP, GEN_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [KIDX_W-1:0] kidx_q, kidx_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [7:0]        out_q, out_d;
  logic              xsig_q, xsig_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              ready_q, busy_q;

  logic [7:0] sbox_q [256];
  logic       we_a, we_b;
  logic [7:0] addr_a, addr_b, dat_a, dat_b;

  logic [7:0] key_byte [KEY_BYTES];
  logic [7:0] s_cnt, j_ksa, sj_ksa;
  logic [7:0] i_inc, si_inc, j_prga, sj_prga, out_idx;

  // Key byte 0 sits in the most significant byte of the latched key.
  for (genvar n = 0; n < KEY_BYTES; n++) begin : g_key
    assign key_byte[n] = key_q[KEY_W-1-8*n -: 8];
  end

`ifdef RC4_DROP_EN
  localparam int unsigned DCNT_W = (DROP_N > 1) ? $clog2(DROP_N) : 1;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
`else
  // Drop depth only matters when the drop stage is built in.
  if (DROP_N == 0) begin : g_no_drop_depth
  end
`endif

  assign s_cnt   = sbox_q[cnt_q];
  assign j_ksa   = j_q + s_cnt + key_byte[kidx_q];
  assign sj_ksa  = sbox_q[j_ksa];
  assign i_inc   = i_q + 8'd1;
  assign si_inc  = sbox_q[i_inc];
  assign j_prga  = j_q + si_inc;
  assign sj_prga = sbox_q[j_prga];
  assign out_idx = sbox_q[i_q] + sbox_q[j_q];

  // Next-state, datapath and S-box write port control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kidx_d  = kidx_q;
    i_d     = i_q;
    j_d     = j_q;
    key_d   = key_q;
    out_d   = out_q;
    xsig_d  = 1'b0;
    pix_d   = xsig_q ? pix_q + PIX_W'(1) : pix_q;
    we_a    = 1'b0;
    we_b    = 1'b0;
    addr_a  = cnt_q;
    addr_b  = j_ksa;
    dat_a   = cnt_q;
    dat_b   = s_cnt;
`ifdef RC4_DROP_EN
    dcnt_d  = dcnt_q;
`endif
    if (start_i) begin
      key_d   = key_i;
      cnt_d   = 8'd0;
      kidx_d  = '0;
      i_d     = 8'd0;
      j_d     = 8'd0;
      out_d   = 8'd0;
      pix_d   = '0;
      state_d = INIT;
    end else begin
      case (state_q)
        IDLE: ;
        INIT: begin
          we_a  = 1'b1;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'hFF) begin
            j_d     = 8'd0;
            kidx_d  = '0;
            state_d = KSA;
          end
        end
        KSA: begin
          we_a   = 1'b1;
          dat_a  = sj_ksa;
          we_b   = 1'b1;
          j_d    = j_ksa;
          cnt_d  = cnt_q + 8'd1;
          kidx_d = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + KIDX_W'(1);
          if (cnt_q == 8'hFF) begin
            i_d = 8'd0;
            j_d = 8'd0;
`ifdef RC4_DROP_EN
            dcnt_d  = '0;
            state_d = DROP;
`else
            state_d = READY;
`endif
          end
        end
`ifdef RC4_DROP_EN
        DROP: begin
          we_a   = 1'b1;
          addr_a = i_inc;
          dat_a  = sj_prga;
          we_b   = 1'b1;
          addr_b = j_prga;
          dat_b  = si_inc;
          i_d    = i_inc;
          j_d    = j_prga;
          dcnt_d = dcnt_q + DCNT_W'(1);
          if (dcnt_q == DCNT_W'(DROP_N - 1)) state_d = READY;
        end
`endif
        READY: if (next_i) state_d = GEN_SWAP;
        GEN_SWAP: begin
          we_a    = 1'b1;
          addr_a  = i_inc;
          dat_a   = sj_prga;
          we_b    = 1'b1;
          addr_b  = j_prga;
          dat_b   = si_inc;
          i_d     = i_inc;
          j_d     = j_prga;
          state_d = GEN_OUT;
        end
        GEN_OUT: begin
          out_d   = sbox_q[out_idx];
          xsig_d  = 1'b1;
          state_d = READY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      kidx_q  <= '0;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      key_q   <= '0;
      out_q   <= 8'd0;
      xsig_q  <= 1'b0;
      pix_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RC4_DROP_EN
      dcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kidx_q  <= kidx_d;
      i_q     <= i_d;
      j_q     <= j_d;
      key_q   <= key_d;
      out_q   <= out_d;
      xsig_q  <= xsig_d;
      pix_q   <= pix_d;
      ready_q <= (state_d == READY);
      busy_q  <= (state_d != IDLE) && (state_d != READY);
`ifdef RC4_DROP_EN
      dcnt_q  <= dcnt_d;
`endif
    end
  end

  // S-box contents are don't-care after reset; INIT rewrites every entry.
  always_ff @(posedge clk) begin
    if (we_a) sbox_q[addr_a] <= dat_a;
    if (we_b) sbox_q[addr_b] <= dat_b;
  end

  assign outputToXor_o = out_q;
  assign xor_sig_o     = xsig_q;
  assign couterPixel_o = pix_q;
  assign ready_o       = ready_q;
  assign busy_o        = busy_q;

endmodule
